// File: rtl/peripheral_div.sv
// Memory-mapped 16-bit unsigned divider peripheral.
// Uses restoring shift-subtract, one quotient bit per clock, MSB first.
module peripheral_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_INIT   = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;
  localparam logic [4:0] ADDR_DONE   = 5'h14;

  state_t      state_r, state_nxt_s;
  logic [15:0] a_r, b_r;
  logic [15:0] op_a_r, op_b_r;
  logic [15:0] quo_r, rem_r;
  logic [3:0]  cnt_r;
  logic [31:0] result_r;
  logic        done_r;
  logic [31:0] d_out_r;

  logic        wr_en_s, rd_en_s, init_wr_s;
  logic        start_s, finish_s;
  logic [16:0] trial_s;
  logic        ge_s;
  logic [15:0] rem_nxt_s, quo_nxt_s;
  logic [31:0] rd_data_s;

  assign wr_en_s   = cs & wr;
  assign rd_en_s   = cs & rd;
  assign init_wr_s = wr_en_s & (addr == ADDR_INIT) & d_in[0];
  assign d_out     = d_out_r;

  // Next-state decode: start only from IDLE, finish after the 16th step.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (init_wr_s) begin
          state_nxt_s = BUSY;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd15) begin
          state_nxt_s = IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One restoring step; with a zero divisor every trial succeeds, giving
  // an all-ones quotient and the dividend as remainder.
  always_comb begin
    trial_s   = {rem_r, op_a_r[15]};
    ge_s      = (trial_s >= {1'b0, op_b_r});
    rem_nxt_s = trial_s[15:0];
    if (ge_s) begin
      rem_nxt_s = trial_s[15:0] - op_b_r;
    end else begin
      rem_nxt_s = trial_s[15:0];
    end
    quo_nxt_s = {quo_r[14:0], ge_s};
  end

  // Read data selection from current (pre-update) register values.
  always_comb begin
    rd_data_s = 32'd0;
    case (addr)
      ADDR_A:      rd_data_s = {16'd0, a_r};
      ADDR_B:      rd_data_s = {16'd0, b_r};
      ADDR_RESULT: rd_data_s = result_r;
      ADDR_DONE:   rd_data_s = {31'd0, done_r};
      default:     rd_data_s = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus-visible registers: operands, result, done flag and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= 16'd0;
      b_r      <= 16'd0;
      result_r <= 32'd0;
      done_r   <= 1'b0;
      d_out_r  <= 32'd0;
    end else begin
      if (wr_en_s && (addr == ADDR_A)) begin
        a_r <= d_in;
      end
      if (wr_en_s && (addr == ADDR_B)) begin
        b_r <= d_in;
      end
      if (rd_en_s) begin
        d_out_r <= rd_data_s;
      end
      if (start_s) begin
        done_r <= 1'b0;
      end else if (finish_s) begin
        done_r   <= 1'b1;
        result_r <= {rem_nxt_s, quo_nxt_s};
      end
    end
  end

  // Division working registers, operands latched at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r <= 16'd0;
      op_b_r <= 16'd0;
      quo_r  <= 16'd0;
      rem_r  <= 16'd0;
      cnt_r  <= 4'd0;
    end else if (start_s) begin
      op_a_r <= a_r;
      op_b_r <= b_r;
      quo_r  <= 16'd0;
      rem_r  <= 16'd0;
      cnt_r  <= 4'd0;
    end else if (state_r == BUSY) begin
      op_a_r <= {op_a_r[14:0], 1'b0};
      quo_r  <= quo_nxt_s;
      rem_r  <= rem_nxt_s;
      cnt_r  <= cnt_r + 4'd1;
    end
  end

endmodule

// File: tb/tb_peripheral_div.sv
// Directed self-checking bench for peripheral_div.
// Inputs change on falling edges; each bus access occupies one clock.
module tb_peripheral_div;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  int n_cmp;
  int n_err;

  peripheral_div dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .cs   (cs),
    .addr (addr),
    .rd   (rd),
    .wr   (wr),
    .d_out(d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle write; caller is at a falling edge, returns at the next one.
  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_div(input logic [15:0] a, input logic [15:0] b);
    bus_write(5'h04, a);
    bus_write(5'h08, b);
    bus_write(5'h0C, 16'h0001);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1; cs = 1'b1; wr = 1'b1; addr = 5'h04; d_in = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; cs = 1'b0; wr = 1'b0;
    n_cmp++;
    if (d_out !== 32'h0) begin n_err++; $display("FAIL reset_dout got %h exp %h", d_out, 32'h0); end
    bus_read(5'h04, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_a got %h exp %h", r, 32'h0); end
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_done got %h exp %h", r, 32'h0); end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp %h", r, 32'h0); end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    start_div(16'h0063, 16'h0009);
    idle(17);
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h00000001) begin n_err++; $display("FAIL basic_done got %h exp %h", r, 32'h1); end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0000000B) begin n_err++; $display("FAIL basic_result got %h exp %h", r, 32'hB); end
    bus_read(5'h08, r);
    n_cmp++;
    if (r !== 32'h00000009) begin n_err++; $display("FAIL basic_b_readback got %h exp %h", r, 32'h9); end
  endtask

  task automatic test_overwrite;
    logic [31:0] r;
    start_div(16'h0063, 16'h0009);
    idle(1);
    bus_write(5'h04, 16'h0000);
    idle(16);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0000000B) begin n_err++; $display("FAIL ovw_result got %h exp %h", r, 32'hB); end
    bus_read(5'h04, r);
    n_cmp++;
    if (r !== 32'h00000000) begin n_err++; $display("FAIL ovw_a got %h exp %h", r, 32'h0); end
  endtask

  task automatic test_results;
    logic [31:0] r;
    start_div(16'd100, 16'd7);
    idle(17);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0002000E) begin n_err++; $display("FAIL rem_result got %h exp %h", r, 32'h0002000E); end
    start_div(16'hFFFF, 16'h0001);
    idle(17);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0000FFFF) begin n_err++; $display("FAIL max_div1 got %h exp %h", r, 32'h0000FFFF); end
    start_div(16'h0005, 16'h0007);
    idle(17);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h00050000) begin n_err++; $display("FAIL small_a got %h exp %h", r, 32'h00050000); end
    start_div(16'hFFFF, 16'hFFFF);
    idle(17);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h00000001) begin n_err++; $display("FAIL equal_ops got %h exp %h", r, 32'h1); end
  endtask

  task automatic test_div_zero;
    logic [31:0] r;
    start_div(16'd5, 16'd0);
    idle(15);
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL dz_done_early got %h exp %h", r, 32'h0); end
    idle(1);
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h1) begin n_err++; $display("FAIL dz_done got %h exp %h", r, 32'h1); end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0005FFFF) begin n_err++; $display("FAIL dz_result got %h exp %h", r, 32'h0005FFFF); end
  endtask

  task automatic test_busy_window;
    logic [31:0] r;
    bus_write(5'h04, 16'd50);
    bus_write(5'h08, 16'd6);
    bus_write(5'h0C, 16'h0001);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        bus_write(5'h0C, 16'h0001);
      end else begin
        bus_read(5'h14, r);
        n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL busy_done_T%0d got %h exp %h", k, r, 32'h0); end
      end
    end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0005FFFF) begin n_err++; $display("FAIL busy_result_pre got %h exp %h", r, 32'h0005FFFF); end
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h1) begin n_err++; $display("FAIL busy_done_T17 got %h exp %h", r, 32'h1); end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h00020008) begin n_err++; $display("FAIL busy_result got %h exp %h", r, 32'h00020008); end
  endtask

  task automatic test_bus_misc;
    logic [31:0] r;
    bus_write(5'h0C, 16'h0000);
    idle(2);
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h1) begin n_err++; $display("FAIL init0_ignored got %h exp %h", r, 32'h1); end
    bus_write(5'h10, 16'h1234);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h00020008) begin n_err++; $display("FAIL ro_write got %h exp %h", r, 32'h00020008); end
    bus_read(5'h0C, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL read_init got %h exp %h", r, 32'h0); end
    bus_read(5'h04, r);
    bus_read(5'h1C, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL read_unmapped got %h exp %h", r, 32'h0); end
    bus_read(5'h04, r);
    idle(3);
    n_cmp++;
    if (d_out !== 32'd50) begin n_err++; $display("FAIL dout_hold got %h exp %h", d_out, 32'd50); end
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h04; d_in = 16'hA5A5;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    n_cmp++;
    if (d_out !== 32'd50) begin n_err++; $display("FAIL rdwr_pre got %h exp %h", d_out, 32'd50); end
    bus_read(5'h04, r);
    n_cmp++;
    if (r !== 32'h0000A5A5) begin n_err++; $display("FAIL rdwr_post got %h exp %h", r, 32'h0000A5A5); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    start_div(16'h1234, 16'h0003);
    idle(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (d_out !== 32'h0) begin n_err++; $display("FAIL mid_dout got %h exp %h", d_out, 32'h0); end
    idle(20);
    bus_read(5'h14, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL mid_done got %h exp %h", r, 32'h0); end
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL mid_result got %h exp %h", r, 32'h0); end
    start_div(16'h1234, 16'h0003);
    idle(17);
    bus_read(5'h10, r);
    n_cmp++;
    if (r !== 32'h00010611) begin n_err++; $display("FAIL post_reset_div got %h exp %h", r, 32'h00010611); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h00; d_in = 16'h0000;
    @(negedge clk);
    test_reset;
    test_basic;
    test_overwrite;
    test_results;
    test_div_zero;
    test_busy_window;
    test_bus_misc;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
